// File: rtl/ysyx_ifu.sv
// ysyx_ifu -- single-outstanding instruction fetch unit.
//
// This unit issues one read address and waits for its data. It then holds the
// fetched word for the decode stage until that stage consumes it. After the
// consume, it advances to the next pc or to the redirect target.
//
// Ports:
//   clk, rst                       clock; synchronous active-low reset
//   mem_arvalid/araddr/arready     read-address handshake (araddr is pc)
//   mem_rvalid/rdata/rresp/rready  read-data handshake (rresp 2'b00 = OKAY)
//   inst_valid/inst/pc/inst_ready  fetched instruction to decode
//   jump/jump_addr                 redirect, sampled only on a consume
//   fetch_err                      sticky fault (bus error or misaligned jump)
//   fetch_cnt                      number of consumed instructions (wraps)
module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        inst_ready,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_OUT  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Reset value of inst: the canonical nop (addi x0, x0, 0).
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] cnt_r, cnt_s;
  logic        err_r, err_s;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    inst_s  = inst_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    case (state_r)
      S_ADDR: begin
        if (mem_arready) begin
          state_s = S_DATA;
        end else begin
          state_s = S_ADDR;
        end
      end
      S_DATA: begin
        if (mem_rvalid) begin
          if (mem_rresp == 2'b00) begin
            inst_s  = mem_rdata;
            state_s = S_OUT;
          end else begin
            err_s   = 1'b1;
            state_s = S_ERR;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          // The instruction counts as consumed even when the redirect is
          // rejected as misaligned.
          cnt_s = cnt_r + 32'd1;
          if (jump) begin
            if (jump_addr[1:0] != 2'b00) begin
              err_s   = 1'b1;
              state_s = S_ERR;
            end else begin
              pc_s    = jump_addr;
              state_s = S_ADDR;
            end
          end else begin
            pc_s    = pc_r + 32'd4;
            state_s = S_ADDR;
          end
        end else begin
          state_s = S_OUT;
        end
      end
      S_ERR: begin
        err_s   = 1'b1;
        state_s = S_ERR;
      end
      default: begin
        // An unreachable encoding is treated as a fault and parks the unit.
        err_s   = 1'b1;
        state_s = S_ERR;
      end
    endcase
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_ADDR;
      pc_r    <= RESET_PC;
      inst_r  <= NOP_INST;
      cnt_r   <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      inst_r  <= inst_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  // Outputs decode only registered state, so they are glitch-free.
  assign mem_arvalid = (state_r == S_ADDR);
  assign mem_rready  = (state_r == S_DATA);
  assign inst_valid  = (state_r == S_OUT);
  assign mem_araddr  = pc_r;
  assign pc          = pc_r;
  assign inst        = inst_r;
  assign fetch_cnt   = cnt_r;
  assign fetch_err   = err_r;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed testbench for ysyx_ifu.
//
// Two instances share all inputs. dut_a uses the default RESET_PC. dut_b uses
// 32'hFFFF_FFFC, so pc+4 can be seen to wrap.
module tb_ysyx_ifu;

  logic        clk;
  logic        rst;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        inst_ready;
  logic        jump;
  logic [31:0] jump_addr;

  logic        a_arvalid, a_rready, a_inst_valid, a_err;
  logic [31:0] a_araddr, a_inst, a_pc, a_cnt;
  logic        b_arvalid, b_rready, b_inst_valid, b_err;
  logic [31:0] b_araddr, b_inst, b_pc, b_cnt;

  int n_cmp;
  int n_err;

  ysyx_ifu dut_a (
    .clk(clk), .rst(rst),
    .mem_arvalid(a_arvalid), .mem_araddr(a_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(a_rready),
    .inst_valid(a_inst_valid), .inst(a_inst), .pc(a_pc), .inst_ready(inst_ready),
    .jump(jump), .jump_addr(jump_addr),
    .fetch_err(a_err), .fetch_cnt(a_cnt)
  );

  ysyx_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst),
    .mem_arvalid(b_arvalid), .mem_araddr(b_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(b_rready),
    .inst_valid(b_inst_valid), .inst(b_inst), .pc(b_pc), .inst_ready(inst_ready),
    .jump(jump), .jump_addr(jump_addr),
    .fetch_err(b_err), .fetch_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    mem_rresp   = 2'b00;
    inst_ready  = 1'b0;
    jump        = 1'b0;
    jump_addr   = 32'h0;
    cyc();
    cyc();

    // Reset state.
    check("rst_arvalid", {31'd0, a_arvalid}, 32'd1);
    check("rst_rready", {31'd0, a_rready}, 32'd0);
    check("rst_ivalid", {31'd0, a_inst_valid}, 32'd0);
    check("rst_pc", a_pc, 32'h8000_0000);
    check("rst_araddr", a_araddr, 32'h8000_0000);
    check("rst_inst", a_inst, 32'h0000_0013);
    check("rst_cnt", a_cnt, 32'd0);
    check("rst_err", {31'd0, a_err}, 32'd0);
    check("rst_pc_b", b_pc, 32'hFFFF_FFFC);

    // Zero-wait fetch and consume at 8000_0000.
    rst         = 1'b1;
    mem_arready = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0010_0093;
    inst_ready  = 1'b1;
    cyc();
    check("zw_rready", {31'd0, a_rready}, 32'd1);
    check("zw_arvalid", {31'd0, a_arvalid}, 32'd0);
    cyc();
    check("zw_ivalid", {31'd0, a_inst_valid}, 32'd1);
    check("zw_inst", a_inst, 32'h0010_0093);
    check("zw_pc", a_pc, 32'h8000_0000);
    cyc();
    check("zw_next_araddr", a_araddr, 32'h8000_0004);
    check("zw_cnt", a_cnt, 32'd1);
    check("zw_arvalid2", {31'd0, a_arvalid}, 32'd1);
    check("wrap_araddr_b", b_araddr, 32'h0000_0000);

    // Stalled handshakes at 8000_0004.
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    inst_ready  = 1'b0;
    mem_rdata   = 32'h0020_0113;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("st_ar_araddr", a_araddr, 32'h8000_0004);
      check("st_ar_arvalid", {31'd0, a_arvalid}, 32'd1);
    end
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("st_r_rready", {31'd0, a_rready}, 32'd1);
      check("st_r_ivalid", {31'd0, a_inst_valid}, 32'd0);
    end
    mem_rvalid = 1'b1;
    cyc();
    check("st_inst", a_inst, 32'h0020_0113);
    // A held rvalid and a jump on non-consume cycles must have no effect.
    jump      = 1'b1;
    jump_addr = 32'h0000_0200;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("st_o_inst", a_inst, 32'h0020_0113);
      check("st_o_pc", a_pc, 32'h8000_0004);
      check("st_o_ivalid", {31'd0, a_inst_valid}, 32'd1);
      check("st_o_arvalid", {31'd0, a_arvalid}, 32'd0);
      check("st_o_cnt", a_cnt, 32'd1);
    end
    mem_rvalid = 1'b0;
    jump       = 1'b0;
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    check("st_next_araddr", a_araddr, 32'h8000_0008);
    check("st_cnt", a_cnt, 32'd2);

    // Aligned jump on a consume.
    mem_arready = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0030_0193;
    cyc();
    cyc();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    check("j_ivalid", {31'd0, a_inst_valid}, 32'd1);
    check("j_pc", a_pc, 32'h8000_0008);
    jump       = 1'b1;
    jump_addr  = 32'h8000_0100;
    inst_ready = 1'b1;
    cyc();
    jump       = 1'b0;
    inst_ready = 1'b0;
    check("j_araddr", a_araddr, 32'h8000_0100);
    check("j_cnt", a_cnt, 32'd3);

    // Misaligned jump on a consume.
    mem_arready = 1'b1;
    mem_rvalid  = 1'b1;
    cyc();
    cyc();
    check("mj_ivalid", {31'd0, a_inst_valid}, 32'd1);
    jump       = 1'b1;
    jump_addr  = 32'h8000_0102;
    inst_ready = 1'b1;
    cyc();
    jump       = 1'b0;
    inst_ready = 1'b0;
    check("mj_err", {31'd0, a_err}, 32'd1);
    check("mj_pc", a_pc, 32'h8000_0100);
    check("mj_cnt", a_cnt, 32'd4);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("mj_arvalid", {31'd0, a_arvalid}, 32'd0);
      check("mj_rready", {31'd0, a_rready}, 32'd0);
      check("mj_ivalid0", {31'd0, a_inst_valid}, 32'd0);
      check("mj_err_hold", {31'd0, a_err}, 32'd1);
    end

    // A reset pulse clears the fault; then a bus error on the first fetch.
    rst = 1'b0;
    cyc();
    check("rp_err", {31'd0, a_err}, 32'd0);
    check("rp_araddr", a_araddr, 32'h8000_0000);
    check("rp_cnt", a_cnt, 32'd0);
    rst       = 1'b1;
    mem_rresp = 2'b10;
    cyc();
    cyc();
    check("be_err", {31'd0, a_err}, 32'd1);
    check("be_inst", a_inst, 32'h0000_0013);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("be_arvalid", {31'd0, a_arvalid}, 32'd0);
    end
    rst = 1'b0;
    cyc();
    check("be_rst_err", {31'd0, a_err}, 32'd0);
    check("be_rst_araddr", a_araddr, 32'h8000_0000);

    // Reset arriving in S_DATA while rvalid is high discards the data.
    mem_rresp  = 2'b00;
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    cyc();
    check("rd_rready", {31'd0, a_rready}, 32'd1);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hABCD_1234;
    inst_ready = 1'b1;
    cyc();
    check("rd_inst", a_inst, 32'h0000_0013);
    check("rd_pc", a_pc, 32'h8000_0000);
    check("rd_pc_b", b_pc, 32'hFFFF_FFFC);
    check("rd_ivalid", {31'd0, a_inst_valid}, 32'd0);
    check("rd_rready0", {31'd0, a_rready}, 32'd0);
    // A late rvalid in S_ADDR is ignored.
    rst         = 1'b1;
    mem_arready = 1'b0;
    cyc();
    check("late_arvalid", {31'd0, a_arvalid}, 32'd1);
    check("late_araddr", a_araddr, 32'h8000_0000);
    check("late_inst", a_inst, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu.md
YSYX_IFU -- requirements
Module: ysyx_ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 mem_arvalid  output  1  fetch-address request valid.
REQ-005 mem_araddr  output  32  fetch address (equals pc).
REQ-006 mem_arready  input  1  memory accepts address.
REQ-007 mem_rvalid  input  1  read data valid.
REQ-008 mem_rdata  input  32  fetched instruction word.
REQ-009 mem_rresp  input  2  read response; 2'b00 OKAY, anything else error.
REQ-010 mem_rready  output  1  IFU accepts read data.
REQ-011 inst_valid  output  1  inst/pc hold a fetched instruction for the decode stage.
REQ-012 inst  output  32  fetched instruction word.
REQ-013 pc  output  32  address of the instruction on inst.
REQ-014 inst_ready  input  1  decode/execute consumes current instruction this cycle.
REQ-015 jump  input  1  next pc is jump_addr; sampled only on consume handshake.
REQ-016 jump_addr  input  32  redirect target.
REQ-017 fetch_err  output  1  sticky fetch fault flag.
REQ-018 fetch_cnt  output  32  count of consumed instructions.

Function
REQ-019 FSM states: S_ADDR, S_DATA, S_OUT, S_ERR; exactly one active.
REQ-020 S_ADDR: mem_arvalid=1, mem_araddr=pc; on mem_arready=1 -> S_DATA; otherwise stay, mem_araddr held stable.
REQ-021 S_DATA: mem_rready=1; on mem_rvalid=1 with mem_rresp=0 -> latch mem_rdata into inst, -> S_OUT.
REQ-022 S_DATA: mem_rvalid=1 with mem_rresp!=0 -> fetch_err=1, -> S_ERR; inst unchanged.
REQ-023 S_OUT: inst_valid=1; inst and pc held stable until inst_ready=1.
REQ-024 S_OUT with inst_ready=1: pc <= jump ? jump_addr : pc+4; fetch_cnt += 1; -> S_ADDR next cycle.
REQ-025 pc+4 and fetch_cnt wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0; fetch_cnt FFFF_FFFF -> 0).
REQ-026 Consume with jump=1 and jump_addr[1:0]!=0: pc unchanged, fetch_cnt still increments, fetch_err=1, -> S_ERR.
REQ-027 S_ERR: terminal until reset; arvalid, rready, inst_valid all 0; fetch_err held 1.
REQ-028 mem_rready=0 outside S_DATA; mem_rvalid outside S_DATA ignored, no state change.
REQ-029 mem_arvalid=0 outside S_ADDR; inst_valid=0 outside S_OUT.
REQ-030 jump/jump_addr ignored except on S_OUT consume cycle.
REQ-031 Minimum throughput: 3 cycles per instruction (arready, rvalid, inst_ready each high on first opportunity).
REQ-032 Only one outstanding read; no new address issued before data returned.

Reset
REQ-033 rst=0 at a rising edge: state=S_ADDR, pc=RESET_PC, inst=32'h0000_0013, fetch_cnt=0, fetch_err=0, regardless of current state.
REQ-034 During and immediately after reset: mem_arvalid=1 first cycle after rst deasserts, mem_rready=0, inst_valid=0.
REQ-035 Reset mid-transaction (S_DATA or S_OUT) discards in-flight data; a late mem_rvalid in S_ADDR is ignored.
REQ-036 Reset overrides all other inputs in the same cycle, including inst_ready and mem_rvalid.

Verification
REQ-037 Zero-wait memory returning 32'h0010_0093 at 8000_0000, inst_ready=1 -> inst_valid high 2 cycles after rst release, pc=8000_0000, next araddr=8000_0004, fetch_cnt=1.
REQ-038 mem_arready low 3 cycles, rvalid delayed 2 cycles, inst_ready low 4 cycles -> araddr/inst/pc stable throughout, exactly one fetch, fetch_cnt increments once.
REQ-039 Consume with jump=1, jump_addr=8000_0100 -> next mem_araddr=8000_0100; jump=1 on a non-consume cycle -> no effect.
REQ-040 mem_rresp=2'b10 on first fetch -> fetch_err=1, S_ERR, no further arvalid; rst pulse low -> fetch_err=0, araddr=8000_0000.
REQ-041 jump_addr=8000_0102 on consume -> fetch_err=1, pc remains old value, fetch_cnt incremented.
REQ-042 RESET_PC=32'hFFFF_FFFC, consume without jump -> next araddr=0; rst asserted during S_DATA with rvalid high -> inst=32'h0000_0013, pc=RESET_PC.
